// File: rtl/pdp_bist_pkg.sv
// rtl/pdp_bist_pkg.sv - shared types, LFSR step and pattern generator for the PDP RAM BIST engine
package pdp_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_RW    = 3'd3,
        ST_RD_DN = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } bist_state_e;

    typedef enum logic [1:0] {
        MODE_SWEEP   = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_MARCH   = 2'd3
    } bist_mode_e;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
    endfunction

    // 64-bit pattern for address a; the caller truncates to its data width.
    // The checkerboard only fills an even number of bits so odd widths keep a zero MSB.
    function automatic logic [63:0] pattern(input bist_mode_e mode, input logic [31:0] addr,
                                            input logic [31:0] lfsr, input int unsigned dw);
        logic [63:0] even_mask;
        logic [63:0] cb;
        even_mask = (dw >= 64) ? {64{1'b1}} : ((64'd1 << (dw - (dw % 2))) - 64'd1);
        cb        = 64'h5555_5555_5555_5555 & even_mask;
        case (mode)
            MODE_SWEEP:   pattern = {32'd0, addr};
            MODE_CHECKER: pattern = addr[0] ? ~cb : cb;
            MODE_LFSR:    pattern = {lfsr, lfsr};
            default:      pattern = 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/pdp_bist_chk.sv
// rtl/pdp_bist_chk.sv - read-latency aligned expected-data pipe, comparator and error log
module pdp_bist_chk
    import pdp_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clr_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] exp_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [15:0]           err_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o
);

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0] exp_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] exp_d [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] adr_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] adr_d [RD_LATENCY];
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_q, fail_d;
    logic                  mismatch;

    // Shift the pipe, compare its oldest entry with RAM data, and update the error log
    always_comb begin
        vld_d[0] = push_i;
        exp_d[0] = exp_i;
        adr_d[0] = addr_i;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            exp_d[i] = exp_q[i-1];
            adr_d[i] = adr_q[i-1];
        end
        if (flush_i || clr_i) begin
            vld_d = '0;
        end
        mismatch = vld_q[RD_LATENCY-1] && (rd_data_i !== exp_q[RD_LATENCY-1]);
        err_d    = err_q;
        fail_d   = fail_q;
        if (clr_i) begin
            err_d  = '0;
            fail_d = '0;
        end else if (mismatch) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
                fail_d = adr_q[RD_LATENCY-1];
            end
        end
    end

    // Pipe and error-log registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= '0;
            err_q  <= '0;
            fail_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                exp_q[i] <= '0;
                adr_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            exp_q  <= exp_d;
            adr_q  <= adr_d;
            err_q  <= err_d;
            fail_q <= fail_d;
        end
    end

    assign err_cnt_o   = err_q;
    assign fail_addr_o = fail_q;

endmodule

// File: rtl/pdp_bist_engine.sv
// rtl/pdp_bist_engine.sv - pattern/march traffic generator and checker for one PDP RAM
module pdp_bist_engine
    import pdp_bist_pkg::*;
#(
    parameter int          ADDR_DEPTH = 1024,
    parameter int          ADDR_WIDTH = $clog2(ADDR_DEPTH),
    parameter int          DATA_WIDTH = 18,
    parameter int          BYTE_WIDTH = (DATA_WIDTH >= 9) ? DATA_WIDTH / 9 : 1,
    parameter int          RD_LATENCY = 2,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [1:0]            mode_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [15:0]           err_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [BYTE_WIDTH-1:0] ben_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);
    localparam int                    DCW        = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [DCW-1:0]        DRAIN_LAST = DCW'(RD_LATENCY - 1);

    bist_state_e           state_q, state_d;
    bist_mode_e            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_ph_q, rw_ph_d;
    logic [DCW-1:0]        drain_q, drain_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic                  pass_q, pass_d;

    logic                  start_acc, last, wr_en, rd_en, chk_push;
    logic [DATA_WIDTH-1:0] pat, wdata, chk_exp;

    // Next-state, address sequencing and RAM port drive
    always_comb begin
        start_acc = start_i && !abort_i && (state_q == ST_IDLE);
        pat       = DATA_WIDTH'(pattern(mode_q, 32'(addr_q), lfsr_q, DATA_WIDTH));
        last      = (addr_q == LAST_ADDR);
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        rw_ph_d   = rw_ph_q;
        drain_d   = drain_q;
        lfsr_d    = lfsr_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wdata     = '0;
        chk_push  = 1'b0;
        chk_exp   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_WR;
                    mode_d  = bist_mode_e'(mode_i);
                    addr_d  = '0;
                    lfsr_d  = LFSR_SEED;
                end
            end
            ST_WR: begin
                wr_en  = 1'b1;
                wdata  = (mode_q == MODE_MARCH) ? '0 : pat;
                lfsr_d = lfsr_next(lfsr_q);
                if (last) begin
                    addr_d  = '0;
                    rw_ph_d = 1'b0;
                    lfsr_d  = LFSR_SEED;
                    state_d = (mode_q == MODE_MARCH) ? ST_RW : ST_RD;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_RD: begin
                rd_en    = 1'b1;
                chk_push = 1'b1;
                chk_exp  = pat;
                lfsr_d   = lfsr_next(lfsr_q);
                if (last) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_RW: begin
                // read-expect-0 then write-1 at the same address on consecutive cycles
                if (!rw_ph_q) begin
                    rd_en    = 1'b1;
                    chk_push = 1'b1;
                    chk_exp  = '0;
                    rw_ph_d  = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wdata   = '1;
                    rw_ph_d = 1'b0;
                    if (last) begin
                        state_d = ST_RD_DN;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_RD_DN: begin
                rd_en    = 1'b1;
                chk_push = 1'b1;
                chk_exp  = '1;
                if (addr_q == '0) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q - ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
        end
        pass_d = pass_q;
        if (start_acc) begin
            pass_d = 1'b0;
        end else if (state_q == ST_DONE) begin
            pass_d = (err_cnt_o == 16'd0);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SWEEP;
            addr_q  <= '0;
            rw_ph_q <= 1'b0;
            drain_q <= '0;
            lfsr_q  <= LFSR_SEED;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            rw_ph_q <= rw_ph_d;
            drain_q <= drain_d;
            lfsr_q  <= lfsr_d;
            pass_q  <= pass_d;
        end
    end

    pdp_bist_chk #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (start_acc),
        .flush_i     (abort_i),
        .push_i      (chk_push),
        .exp_i       (chk_exp),
        .addr_i      (addr_q),
        .rd_data_i   (rd_data_i),
        .err_cnt_o   (err_cnt_o),
        .fail_addr_o (fail_addr_o)
    );

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);
    assign pass_o    = (state_q == ST_DONE) ? (err_cnt_o == 16'd0) : pass_q;
    assign wr_en_o   = wr_en;
    assign wr_addr_o = wr_en ? addr_q : '0;
    assign wr_data_o = wdata;
    assign ben_o     = {BYTE_WIDTH{wr_en}};
    assign rd_en_o   = rd_en;
    assign rd_addr_o = rd_en ? addr_q : '0;

endmodule
